// File: rtl/ddr_outbuf.sv
// rtl/ddr_outbuf.sv - DDR output pad buffer: sample-pair FIFO, prime/run/idle control, registered pad outputs
module ddr_outbuf #(
    parameter int               WIDTH       = 32,
    parameter int               DEPTH       = 4,
    parameter int               PRIME_LEVEL = 2,
    parameter logic [WIDTH-1:0] IDLE_VALUE  = '0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_d0,
    input  logic [WIDTH-1:0]           in_d1,
    output logic [WIDTH-1:0]           pad_d0,
    output logic [WIDTH-1:0]           pad_d1,
    output logic                       pad_oe,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       underrun,
    input  logic                       clear_underrun
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [LW-1:0]     level_q, level_d, level_after;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]  pad_d0_q, pad_d0_d, pad_d1_q, pad_d1_d;
    logic              pad_oe_q, pad_oe_d;
    logic              underrun_q, underrun_d;
    logic              push, pop;

    logic [WIDTH-1:0]  mem_d0 [DEPTH];
    logic [WIDTH-1:0]  mem_d1 [DEPTH];

    // Gating with reset_n keeps the source stalled while the block is held in reset.
    assign in_ready    = reset_n && enable && (level_q < LW'(DEPTH));
    assign push        = in_valid && in_ready;
    assign pop         = (state_q == S_RUN) && enable && (level_q != '0);
    assign level_after = level_q + LW'(push);

    always_comb begin
        state_d    = state_q;
        level_d    = level_q + LW'(push) - LW'(pop);
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        underrun_d = underrun_q;

        case (state_q)
            S_IDLE:  if (enable) state_d = S_PRIME;
            S_PRIME: if (level_after >= LW'(PRIME_LEVEL)) state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase

        if (!enable) begin
            state_d  = S_IDLE;
            level_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end

        // Set has priority over clear so an ongoing underrun is never lost.
        if ((state_q == S_RUN) && (level_q == '0)) begin
            underrun_d = 1'b1;
        end else if (clear_underrun) begin
            underrun_d = 1'b0;
        end

        pad_oe_d = (state_d == S_RUN);
        if (state_d != S_RUN) begin
            pad_d0_d = IDLE_VALUE;
            pad_d1_d = IDLE_VALUE;
        end else if (pop) begin
            pad_d0_d = mem_d0[rd_ptr_q];
            pad_d1_d = mem_d1[rd_ptr_q];
        end else begin
            pad_d0_d = pad_d0_q;
            pad_d1_d = pad_d1_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            level_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pad_d0_q   <= IDLE_VALUE;
            pad_d1_q   <= IDLE_VALUE;
            pad_oe_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pad_d0_q   <= pad_d0_d;
            pad_d1_q   <= pad_d1_d;
            pad_oe_q   <= pad_oe_d;
            underrun_q <= underrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_d0[wr_ptr_q] <= in_d0;
            mem_d1[wr_ptr_q] <= in_d1;
        end
    end

    assign pad_d0   = pad_d0_q;
    assign pad_d1   = pad_d1_q;
    assign pad_oe   = pad_oe_q;
    assign busy     = (state_q != S_IDLE);
    assign level    = level_q;
    assign underrun = underrun_q;

endmodule
